// File: rtl/param_seq_alu.sv
// param_seq_alu: registered WIDTH-bit ALU with start/done handshake, carry chaining and a shift-add multiplier.
module param_seq_alu #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic             illegal_op
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mcand, alu_r;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [WIDTH:0] add_w, sub_w, mul_sum;
  logic [CW-1:0] cnt;
  logic alu_c, alu_v, alu_ill, is_mul, last, a_msb, b_msb;
  assign busy   = (state == MUL);
  assign is_mul = MUL_EN && (operation == 4'b1011);
  assign last   = (cnt == LAST);
  assign a_msb  = input_a[WIDTH-1];
  assign b_msb  = input_b[WIDTH-1];
  // operation[0] selects the carry-in variants (ADC/SBC)
  assign add_w = {1'b0, input_a} + {1'b0, input_b} + {{WIDTH{1'b0}}, operation[0] & carry_out};
  assign sub_w = {1'b0, input_a} - {1'b0, input_b} - {{WIDTH{1'b0}}, operation[0] & carry_out};
  // multiplier bits are consumed from the low half of the accumulator, LSB first
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign acc_nx  = {mul_sum, acc[WIDTH-1:1]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE && start && is_mul) state_nx = MUL;
    else if (state == MUL && last) state_nx = IDLE;
  end
  always_comb begin
    alu_r   = '0;
    alu_c   = carry_out;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (operation)
      4'b0000, 4'b0001: begin
        alu_r = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
        alu_v = (a_msb == b_msb) && (add_w[WIDTH-1] != a_msb);
      end
      4'b0010, 4'b0011: begin
        alu_r = sub_w[WIDTH-1:0];
        alu_c = sub_w[WIDTH];
        alu_v = (a_msb != b_msb) && (sub_w[WIDTH-1] != a_msb);
      end
      4'b0100: alu_r = input_a & input_b;
      4'b0101: alu_r = input_a | input_b;
      4'b0110: alu_r = input_a ^ input_b;
      4'b0111: alu_r = input_a & ~input_b;
      4'b1000: begin
        alu_r = {input_a[WIDTH-2:0], 1'b0};
        alu_c = a_msb;
      end
      4'b1001: begin
        alu_r = {1'b0, input_a[WIDTH-1:1]};
        alu_c = input_a[0];
      end
      4'b1010: begin
        alu_r = {a_msb, input_a[WIDTH-1:1]};
        alu_c = input_a[0];
      end
      default: alu_ill = 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result     <= '0;
      result_hi  <= '0;
      carry_out  <= 1'b0;
      zero       <= 1'b0;
      negative   <= 1'b0;
      overflow   <= 1'b0;
      done       <= 1'b0;
      illegal_op <= 1'b0;
      mcand      <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      done       <= 1'b0;
      illegal_op <= 1'b0;
      if (state == IDLE && start) begin
        if (is_mul) begin
          mcand <= input_a;
          acc   <= {{WIDTH{1'b0}}, input_b};
          cnt   <= '0;
        end else begin
          result     <= alu_r;
          result_hi  <= '0;
          carry_out  <= alu_c;
          zero       <= (alu_r == '0);
          negative   <= alu_r[WIDTH-1];
          overflow   <= alu_v;
          done       <= 1'b1;
          illegal_op <= alu_ill;
        end
      end else if (state == MUL) begin
        acc <= acc_nx;
        cnt <= cnt + CW'(1);
        if (last) begin
          result    <= acc_nx[WIDTH-1:0];
          result_hi <= acc_nx[2*WIDTH-1:WIDTH];
          carry_out <= |acc_nx[2*WIDTH-1:WIDTH];
          zero      <= (acc_nx == '0);
          negative  <= acc_nx[WIDTH-1];
          overflow  <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_param_seq_alu.sv
// tb_param_seq_alu: directed bench for param_seq_alu; u0 has MUL enabled, u1 has MUL decoding as reserved.
module tb_param_seq_alu;
  logic clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, start1 = 1'b0;
  logic [3:0] op = '0;
  logic [7:0] a = '0, b = '0;
  logic [7:0] r0, rh0, r1, rh1;
  logic c0, z0, n0, v0, b0, d0, i0, c1, z1, n1, v1, b1, d1, i1;
  int tests = 0, fails = 0;

  param_seq_alu #(.WIDTH(8), .MUL_EN(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .operation(op), .input_a(a), .input_b(b),
    .result(r0), .result_hi(rh0), .carry_out(c0), .zero(z0), .negative(n0), .overflow(v0),
    .busy(b0), .done(d0), .illegal_op(i0));
  param_seq_alu #(.WIDTH(8), .MUL_EN(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .operation(op), .input_a(a), .input_b(b),
    .result(r1), .result_hi(rh1), .carry_out(c1), .zero(z1), .negative(n1), .overflow(v1),
    .busy(b1), .done(d1), .illegal_op(i1));

  always #5 clk = ~clk;

  // one-cycle request; returns 1 time unit after the accepting edge
  task automatic issue(input bit sel, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    op = o; a = x; b = y;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if ({r0, rh0, c0, z0, n0, v0, b0, d0, i0} !== 23'd0) begin fails++; $display("FAIL reset_u0 got %h want 0", {r0, rh0, c0, z0, n0, v0, b0, d0, i0}); end
    tests++; if ({r1, rh1, c1, z1, n1, v1, b1, d1, i1} !== 23'd0) begin fails++; $display("FAIL reset_u1 got %h want 0", {r1, rh1, c1, z1, n1, v1, b1, d1, i1}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    issue(0, 4'b0000, 8'hC8, 8'h64);
    tests++; if (r0 !== 8'h2C) begin fails++; $display("FAIL add_result got %h want 2c", r0); end
    tests++; if ({c0, v0, d0} !== 3'b101) begin fails++; $display("FAIL add_flags c/v/done got %b want 101", {c0, v0, d0}); end
    issue(0, 4'b0001, 8'h7F, 8'h00);
    tests++; if (r0 !== 8'h80) begin fails++; $display("FAIL adc_result got %h want 80", r0); end
    tests++; if ({c0, v0, n0, z0} !== 4'b0110) begin fails++; $display("FAIL adc_flags c/v/n/z got %b want 0110", {c0, v0, n0, z0}); end
    @(posedge clk);
    #1;
    tests++; if (d0 !== 1'b0) begin fails++; $display("FAIL add_done_pulse got %b want 0", d0); end
  endtask

  task automatic test_sub;
    issue(0, 4'b0010, 8'h05, 8'h05);
    tests++; if ({r0, z0, c0} !== {8'h00, 2'b10}) begin fails++; $display("FAIL sub_res_z_c got %h want 002", {r0, z0, c0}); end
    issue(0, 4'b0000, 8'hFF, 8'h01);
    tests++; if (c0 !== 1'b1) begin fails++; $display("FAIL carry_preset got %b want 1", c0); end
    issue(0, 4'b0011, 8'h00, 8'h00);
    tests++; if (r0 !== 8'hFF) begin fails++; $display("FAIL sbc_result got %h want ff", r0); end
    tests++; if ({c0, n0, z0, v0} !== 4'b1100) begin fails++; $display("FAIL sbc_flags c/n/z/v got %b want 1100", {c0, n0, z0, v0}); end
  endtask

  task automatic test_logic;
    logic [7:0] exp [4] = '{8'h30, 8'hFC, 8'hCC, 8'hC0};
    for (int i = 0; i < 4; i++) begin
      issue(0, 4'(4 + i), 8'hF0, 8'h3C);
      tests++; if ({r0, c0, v0} !== {exp[i], 2'b10}) begin fails++; $display("FAIL logic_%0d res/c/v got %h want %h", i, {r0, c0, v0}, {exp[i], 2'b10}); end
    end
  endtask

  task automatic test_back_to_back;
    issue(0, 4'b1000, 8'h81, 8'h00);
    tests++; if ({r0, c0, d0} !== {8'h02, 2'b11}) begin fails++; $display("FAIL shl res/c/done got %h want 0b", {r0, c0, d0}); end
    issue(0, 4'b1001, 8'h01, 8'h00);
    tests++; if ({r0, z0, c0, d0} !== {8'h00, 3'b111}) begin fails++; $display("FAIL shr res/z/c/done got %h want 07", {r0, z0, c0, d0}); end
    issue(0, 4'b1010, 8'h81, 8'h00);
    tests++; if ({r0, c0, n0, v0} !== {8'hC0, 3'b110}) begin fails++; $display("FAIL asr res/c/n/v got %h want 606", {r0, c0, n0, v0}); end
  endtask

  task automatic test_mul;
    int ndone = 0;
    bit busy_ok = 1'b1;
    @(negedge clk);
    op = 4'b1011; a = 8'hFF; b = 8'hFF; start0 = 1'b1;
    @(posedge clk);
    #1;
    tests++; if ({b0, d0} !== 2'b10) begin fails++; $display("FAIL mul_start busy/done got %b want 10", {b0, d0}); end
    a = 8'h02; b = 8'h03;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (d0) ndone++;
      if (i < 8 && (b0 !== 1'b1 || d0 !== 1'b0)) busy_ok = 1'b0;
    end
    tests++; if (!busy_ok) begin fails++; $display("FAIL mul_busy_window got bad want busy=1 done=0"); end
    tests++; if ({d0, b0} !== 2'b10) begin fails++; $display("FAIL mul_done_edge done/busy got %b want 10", {d0, b0}); end
    tests++; if ({rh0, r0} !== 16'hFE01) begin fails++; $display("FAIL mul_product got %h want fe01", {rh0, r0}); end
    tests++; if ({c0, z0, v0, n0} !== 4'b1000) begin fails++; $display("FAIL mul_flags c/z/v/n got %b want 1000", {c0, z0, v0, n0}); end
    @(negedge clk);
    start0 = 1'b0;
    @(posedge clk);
    #1;
    tests++; if ({ndone, b0, d0} !== {32'd1, 2'b00}) begin fails++; $display("FAIL mul_single_accept dones=%0d busy=%b done=%b want 1,0,0", ndone, b0, d0); end
  endtask

  task automatic test_reset_mid_mul;
    bit quiet = 1'b1;
    @(negedge clk);
    op = 4'b1011; a = 8'h0F; b = 8'h0F; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++; if ({r0, rh0, c0, z0, n0, v0, b0, d0, i0} !== 23'd0) begin fails++; $display("FAIL mid_mul_reset got %h want 0", {r0, rh0, c0, z0, n0, v0, b0, d0, i0}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (d0 !== 1'b0 || b0 !== 1'b0) quiet = 1'b0;
    end
    tests++; if (!quiet) begin fails++; $display("FAIL aborted_mul got done/busy activity want none"); end
    issue(0, 4'b0000, 8'h01, 8'h01);
    tests++; if ({r0, d0, c0} !== {8'h02, 2'b10}) begin fails++; $display("FAIL post_reset_add res/done/c got %h want 0a", {r0, d0, c0}); end
  endtask

  task automatic test_reserved;
    issue(0, 4'b1000, 8'hC0, 8'h00);
    tests++; if ({r0, c0} !== {8'h80, 1'b1}) begin fails++; $display("FAIL rsv_preset_u0 got %h want 101", {r0, c0}); end
    issue(0, 4'b1100, 8'h55, 8'h33);
    tests++; if ({r0, rh0, z0, n0, v0, c0} !== {16'h0, 4'b1001}) begin fails++; $display("FAIL rsv_u0 res/hi/z/n/v/c got %h want 00009", {r0, rh0, z0, n0, v0, c0}); end
    tests++; if ({i0, d0, b0} !== 3'b110) begin fails++; $display("FAIL rsv_u0 ill/done/busy got %b want 110", {i0, d0, b0}); end
    @(posedge clk);
    #1;
    tests++; if ({i0, d0} !== 2'b00) begin fails++; $display("FAIL rsv_u0_pulse ill/done got %b want 00", {i0, d0}); end
    issue(1, 4'b1000, 8'hC0, 8'h00);
    tests++; if ({r1, c1} !== {8'h80, 1'b1}) begin fails++; $display("FAIL rsv_preset_u1 got %h want 101", {r1, c1}); end
    issue(1, 4'b1011, 8'hFF, 8'hFF);
    tests++; if ({r1, rh1, z1, n1, v1, c1} !== {16'h0, 4'b1001}) begin fails++; $display("FAIL nomul_u1 res/hi/z/n/v/c got %h want 00009", {r1, rh1, z1, n1, v1, c1}); end
    tests++; if ({i1, d1, b1} !== 3'b110) begin fails++; $display("FAIL nomul_u1 ill/done/busy got %b want 110", {i1, d1, b1}); end
    @(posedge clk);
    #1;
    tests++; if ({i1, d1, b1} !== 3'b000) begin fails++; $display("FAIL nomul_u1_pulse ill/done/busy got %b want 000", {i1, d1, b1}); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_logic;
    test_back_to_back;
    test_mul;
    test_reset_mid_mul;
    test_reserved;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/param_seq_alu.md
Name: param_seq_alu

Overview:
- WIDTH-parametrised, registered ALU. Generalises the 8-bit combinational datapath ALU.
- Adds a start/busy/done handshake, an internal carry flag for ADC/SBC chaining, shift ops, and a multi-cycle shift-add multiplier.
- Sits between the register-file read stage and write-back. The controller issues one op at a time and waits for done.

Parameters:
- WIDTH, 8, datapath width in bits; legal values >= 2.
- MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL decodes as reserved.

Ports:
- clk  in  1  single system clock, rising edge.
- rstN  in  1  reset; asynchronous, active-low.
- start  in  1  request; accepted at a rising edge when start=1 and busy=0.
- operation  in  4  opcode, sampled on accept.
- inputA  in  WIDTH  operand A, sampled on accept.
- inputB  in  WIDTH  operand B, sampled on accept.
- result  out  WIDTH  registered result, low half for MUL.
- resultHi  out  WIDTH  upper product half for MUL; 0 for all other ops.
- carryOut  out  1  internal carry flag, registered.
- zero  out  1  1 when the full result is zero.
- negative  out  1  MSB of result.
- overflow  out  1  signed overflow.
- busy  out  1  MUL in progress.
- done  out  1  one-cycle completion pulse.
- illegalOp  out  1  one-cycle pulse, coincident with done, for reserved opcodes.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While rstN=0, all outputs and the carry flag are 0 and the FSM is in IDLE.
- Reset asserted mid-MUL aborts the MUL: no done pulse, partial product discarded.
- FSM has two states, IDLE and MUL.
  - IDLE: on accept of a single-cycle op, result and flags are written at that edge T and done=1 for the following cycle. Latency is 1.
  - IDLE: on accept of MUL, go to MUL. busy=1 from after T. Operands are latched; multiplicand, multiplier and a 2*WIDTH accumulator are loaded.
  - MUL: one shift-add iteration per cycle, WIDTH iterations. At edge T+WIDTH, write result/resultHi/flags, set done=1 and busy=0, return to IDLE.
- start while busy=1 is ignored, not queued.
- start during a done cycle with busy=0 is accepted, so single-cycle ops run back-to-back at 1 per cycle.
- done and illegalOp are 0 in every cycle not explicitly pulsed.
- result and flags hold their values between operations.
- Opcodes (A = inputA, B = inputB, C = carry flag):
  - 0000 ADD: A+B.
  - 0001 ADC: A+B+C.
  - 0010 SUB: A-B.
  - 0011 SBC: A-B-C.
  - 0100 AND.
  - 0101 OR.
  - 0110 XOR.
  - 0111 ANDN: A & ~B.
  - 1000 SHL: A<<1; C = old A[WIDTH-1].
  - 1001 SHR: logical right shift of A by 1; C = old A[0].
  - 1010 ASR: arithmetic right shift of A by 1; C = old A[0].
  - 1011 MUL: unsigned A*B; {resultHi, result} = 2*WIDTH product.
  - 1100-1111: reserved; also 1011 when MUL_EN=0.
- Arithmetic ops compute in WIDTH+1 bits.
  - ADD/ADC: C = carry out.
  - SUB/SBC: C = borrow, i.e. 1 when the unsigned result went negative.
  - overflow is signed: ADD/ADC when both operand signs are equal and differ from the result sign; SUB/SBC when operand signs differ and the result sign differs from A.
- Logic ops: carry flag unchanged; overflow = 0.
- Shifts: overflow = 0.
- MUL: C = |resultHi; overflow = 0; zero is 1 only when the full 2*WIDTH product is 0.
- zero = (result == 0) for all non-MUL ops. negative = result[WIDTH-1] for all ops.
- Reserved opcodes: single-cycle; result = 0, resultHi = 0, zero = 1, negative = 0, overflow = 0, carry unchanged; illegalOp and done pulse together.
- resultHi is written to 0 on every non-MUL completion.

Test Plan (WIDTH=8, MUL_EN=1 unless stated):
1. ADD 0xC8+0x64, then ADC 0x7F+0x00 -> first: result 0x2C, carryOut 1, overflow 0, done one cycle after accept; second: result 0x80, carryOut 0, overflow 1, negative 1.
2. SUB 0x05-0x05, then SBC 0x00-0x00 with carry preset to 1 -> first: result 0x00, zero 1, carryOut 0; second: result 0xFF, carryOut 1, negative 1.
3. MUL 0xFF*0xFF, with start held high throughout busy -> busy for 8 cycles; resultHi 0xFE, result 0x01, carryOut 1; exactly one done at edge T+8; no extra accepts while busy.
4. Assert rstN=0 four cycles into MUL 0x0F*0x0F, then release and issue ADD 0x01+0x01 -> all outputs 0 and busy 0 immediately; no done for the MUL; ADD completes with result 0x02 after 1 cycle.
5. Back-to-back: SHL 0x81 then SHR 0x01 on consecutive cycles -> first: result 0x02, carryOut 1; second: result 0x00, zero 1, carryOut 1; done high on two consecutive cycles.
6. Reserved opcode 1100 with carry=1, and MUL with MUL_EN=0 -> result 0, zero 1, carryOut stays 1, illegalOp and done pulse together for one cycle, busy never asserted.
